mem_bus_decoder: RTL and testbench
==================================

MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder
Sits downstream of the instruction/data bus arbiter. Decodes the common memory bus onto RAM and IO slave ports, with registered strobes, slave timeout and unmapped-address fault.

Interface
REQ-001 Parameter RAM_BASE, 32'h0000_0000, RAM region base, aligned to 2**RAM_SIZE_LOG2.
REQ-002 Parameter RAM_SIZE_LOG2, 16, RAM region size as log2 bytes.
REQ-003 Parameter IO_BASE, 32'hF000_0000, IO region base, aligned to 2**IO_SIZE_LOG2.
REQ-004 Parameter IO_SIZE_LOG2, 12, IO region size as log2 bytes.
REQ-005 Parameter TIMEOUT_CYCLES, 16, number of ce_i cycles without ack before fault; range 2..255.
REQ-006 Ports, in order:
- clk  in  1  sole clock; single clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce_i  in  1  clock enable; state advances only when high.
- address_in  in  32  request address.
- read_in  in  1  read request, held until ready_out.
- write_in  in  1  write request, held until ready_out.
- write_mask_in  in  4  byte enables.
- write_value_in  in  32  write data.
- read_value_out  out  32  registered read data.
- ready_out  out  1  request complete.
- fault_out  out  1  request failed; valid with ready_out.
- slv_sel_out  out  2  one-hot select; bit0 RAM, bit1 IO.
- slv_address_out  out  32  latched full address.
- slv_read_out  out  1  read strobe.
- slv_write_out  out  1  write strobe.
- slv_write_mask_out  out  4  latched mask.
- slv_write_value_out  out  32  latched write data.
- slv_read_value_in  in  64  [31:0] RAM data, [63:32] IO data.
- slv_ack_in  in  2  per-slave ack; only the selected bit is honoured.

Function
REQ-007 FSM states: IDLE, ACCESS, RESPOND. All transitions require ce_i=1; with ce_i=0 state, counter and all outputs hold.
REQ-008 IDLE, request (read_in or write_in) to a mapped region: latch address, mask, write data, read/write and select; go to ACCESS.
REQ-009 Region match compares address_in[31:SIZE_LOG2] against BASE[31:SIZE_LOG2]. On overlap, RAM wins.
REQ-010 IDLE, request to an unmapped address: go directly to RESPOND with fault flag set. No slave strobe is asserted.
REQ-011 IDLE, read_in and write_in both high: treat as unmapped (fault, no strobe).
REQ-012 slv_sel_out, slv_read_out and slv_write_out are registered and asserted only while in ACCESS. They are 0 in IDLE and RESPOND.
REQ-013 ACCESS, selected slv_ack_in bit high: capture that slave's read data into read_value_out (reads only; writes leave it unchanged), clear fault flag, go to RESPOND.
REQ-014 ACCESS timeout counter is 8 bits. It clears on entry to ACCESS and increments each ce_i cycle without ack.
REQ-015 When the counter equals TIMEOUT_CYCLES-1 and there is no ack: go to RESPOND with fault flag set. If ack and timeout occur in the same cycle, ack wins.
REQ-016 RESPOND: ready_out=1 and fault_out=fault flag. The next ce_i cycle returns to IDLE; ready_out is high for exactly one ce_i cycle.
REQ-017 ready_out and fault_out are 0 outside RESPOND.
REQ-018 Upstream changes to the request inputs during ACCESS or RESPOND are ignored (latched copy is used).
REQ-019 Latency with ce_i held high:
- Mapped access, ack in the first ACCESS cycle: ready_out two cycles after request acceptance.
- Unmapped access: ready_out one cycle after request acceptance.
REQ-020 A new request is accepted only in IDLE. The cycle after RESPOND, there is no back-to-back acceptance.

Reset
REQ-021 reset has priority over ce_i and forces:
- State IDLE, counter 0, fault flag 0.
- ready_out 0, fault_out 0, read_value_out 0.
- All slv_* outputs 0.
REQ-022 Reset during ACCESS drops the strobes on the same edge; a later ack from the aborted slave is ignored in IDLE.

Structure
REQ-023 Package mem_bus_pkg holds:
- FSM state enum.
- Slave index constants SLV_RAM=0, SLV_IO=1.
- Slave count constant NUM_SLAVES=2.
REQ-024 One sub-module, mem_bus_region_match: combinational BASE/SIZE_LOG2 address comparator, instantiated once per region.

Verification
REQ-025 RAM read 0x0000_0100, ack in first ACCESS cycle with data 0xDEADBEEF:
- RAM strobe for one cycle.
- ready_out at +2 cycles, read_value_out 0xDEADBEEF, fault_out 0.
REQ-026 IO write 0xF000_0004, mask 4'b0011, data 0x1234_5678, ack after 3 cycles:
- slv_sel_out 2'b10; latched mask and data presented on slv_* ports.
- ready_out once, fault_out 0.
REQ-027 Read 0x8000_0000 (unmapped): ready_out and fault_out at +1 cycle; slv_read_out never asserted.
REQ-028 RAM read with no ack, TIMEOUT_CYCLES=16:
- fault_out with ready_out after exactly 16 ACCESS cycles.
- Ack in the 16th cycle instead gives fault_out 0.
REQ-029 ce_i toggling 1-0-1 during ACCESS and RESPOND: state and ready_out freeze while ce_i=0; ready_out deasserts only after a ce_i=1 cycle.
REQ-030 Reset asserted in the second ACCESS cycle: strobes 0 next cycle; a late ack produces no ready_out.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus decoder: FSM states,
// slave indices/selects and the slave read-data mux helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPOND
    } state_e;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_SLAVES = 2;
    localparam int unsigned SLV_RAM    = 0;
    localparam int unsigned SLV_IO     = 1;

    localparam logic [NUM_SLAVES-1:0] SEL_NONE = '0;
    localparam logic [NUM_SLAVES-1:0] SEL_RAM  = NUM_SLAVES'(1 << SLV_RAM);
    localparam logic [NUM_SLAVES-1:0] SEL_IO   = NUM_SLAVES'(1 << SLV_IO);

    // Picks the selected slave's word from the concatenated read-data bus.
    function automatic logic [DATA_W-1:0] slave_word(
        input logic [NUM_SLAVES*DATA_W-1:0] bus,
        input logic [NUM_SLAVES-1:0]        sel
    );
        return (sel == SEL_IO) ? bus[2*DATA_W-1:DATA_W] : bus[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mem_bus_region_match.sv
// Combinational region comparator: hit when the address bits above
// SIZE_LOG2 equal those of BASE.
module mem_bus_region_match #(
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int unsigned SIZE_LOG2 = 16
) (
    input  logic [31:0] address_in,
    output logic        hit_out
);

    always_comb begin
        hit_out = ((address_in >> SIZE_LOG2) == (BASE >> SIZE_LOG2));
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Decodes the common memory bus onto RAM and IO slave ports with registered
// strobes, per-access timeout and unmapped-address fault reporting.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter int unsigned RAM_SIZE_LOG2  = 16,
    parameter logic [31:0] IO_BASE        = 32'hF000_0000,
    parameter int unsigned IO_SIZE_LOG2   = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_i,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        fault_out,
    output logic [1:0]  slv_sel_out,
    output logic [31:0] slv_address_out,
    output logic        slv_read_out,
    output logic        slv_write_out,
    output logic [3:0]  slv_write_mask_out,
    output logic [31:0] slv_write_value_out,
    input  logic [63:0] slv_read_value_in,
    input  logic [1:0]  slv_ack_in
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    fault_q, fault_d;
    logic                    ready_q, ready_d;
    logic [31:0]             rvalue_q, rvalue_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [31:0]             addr_q, addr_d;
    logic [3:0]              mask_q, mask_d;
    logic [31:0]             wval_q, wval_d;

    logic ram_hit;
    logic io_hit;
    logic ack;

    mem_bus_region_match #(
        .BASE      (RAM_BASE),
        .SIZE_LOG2 (RAM_SIZE_LOG2)
    ) u_ram_match (
        .address_in (address_in),
        .hit_out    (ram_hit)
    );

    mem_bus_region_match #(
        .BASE      (IO_BASE),
        .SIZE_LOG2 (IO_SIZE_LOG2)
    ) u_io_match (
        .address_in (address_in),
        .hit_out    (io_hit)
    );

    // Only the ack bit of the currently selected slave counts.
    assign ack = |(slv_ack_in & sel_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        ready_d  = ready_q;
        rvalue_d = rvalue_q;
        sel_d    = sel_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        wval_d   = wval_q;

        if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (read_in || write_in) begin
                        if (!(read_in && write_in) && (ram_hit || io_hit)) begin
                            addr_d  = address_in;
                            mask_d  = write_mask_in;
                            wval_d  = write_value_in;
                            rd_d    = read_in;
                            wr_d    = write_in;
                            sel_d   = ram_hit ? SEL_RAM : SEL_IO;
                            cnt_d   = '0;
                            state_d = ST_ACCESS;
                        end else begin
                            fault_d = 1'b1;
                            ready_d = 1'b1;
                            state_d = ST_RESPOND;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ack || (cnt_q == TIMEOUT_LAST)) begin
                        if (ack && rd_q) begin
                            rvalue_d = slave_word(slv_read_value_in, sel_q);
                        end
                        fault_d = !ack;
                        ready_d = 1'b1;
                        sel_d   = SEL_NONE;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = ST_RESPOND;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RESPOND: begin
                    fault_d = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    fault_d = 1'b0;
                    ready_d = 1'b0;
                    sel_d   = SEL_NONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            ready_q  <= 1'b0;
            rvalue_q <= '0;
            sel_q    <= SEL_NONE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            mask_q   <= '0;
            wval_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            ready_q  <= ready_d;
            rvalue_q <= rvalue_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            wval_q   <= wval_d;
        end
    end

    assign read_value_out      = rvalue_q;
    assign ready_out           = ready_q;
    assign fault_out           = fault_q;
    assign slv_sel_out         = sel_q;
    assign slv_address_out     = addr_q;
    assign slv_read_out        = rd_q;
    assign slv_write_out       = wr_q;
    assign slv_write_mask_out  = mask_q;
    assign slv_write_value_out = wval_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: vector table of single transactions
// plus hand sequences for clock-enable stalls, back-to-back and reset abort.
module tb_mem_bus_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_i;
    logic [31:0] address_in;
    logic        read_in;
    logic        write_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        fault_out;
    logic [1:0]  slv_sel_out;
    logic [31:0] slv_address_out;
    logic        slv_read_out;
    logic        slv_write_out;
    logic [3:0]  slv_write_mask_out;
    logic [31:0] slv_write_value_out;
    logic [63:0] slv_read_value_in;
    logic [1:0]  slv_ack_in;

    always #5 clk = ~clk;

    mem_bus_decoder #(
        .RAM_BASE       (32'h0000_0000),
        .RAM_SIZE_LOG2  (16),
        .IO_BASE        (32'hF000_0000),
        .IO_SIZE_LOG2   (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ce_i                (ce_i),
        .address_in          (address_in),
        .read_in             (read_in),
        .write_in            (write_in),
        .write_mask_in       (write_mask_in),
        .write_value_in      (write_value_in),
        .read_value_out      (read_value_out),
        .ready_out           (ready_out),
        .fault_out           (fault_out),
        .slv_sel_out         (slv_sel_out),
        .slv_address_out     (slv_address_out),
        .slv_read_out        (slv_read_out),
        .slv_write_out       (slv_write_out),
        .slv_write_mask_out  (slv_write_mask_out),
        .slv_write_value_out (slv_write_value_out),
        .slv_read_value_in   (slv_read_value_in),
        .slv_ack_in          (slv_ack_in)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int unsigned ack_dly;   // ACCESS cycle in which ack first appears; 0 = never
        logic [1:0]  ack_bits;
        logic [31:0] ram_data;
        logic [31:0] io_data;
        int unsigned exp_lat;   // cycles from acceptance edge count to ready_out
        logic        exp_fault;
        logic [1:0]  exp_sel;
        logic [31:0] exp_rv;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(
        input string n, input logic rd, input logic wr, input logic [31:0] a,
        input logic [3:0] m, input logic [31:0] wd, input int unsigned dly,
        input logic [1:0] ab, input logic [31:0] rdat, input logic [31:0] idat,
        input int unsigned lat, input logic f, input logic [1:0] sel,
        input logic [31:0] rv
    );
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.mask = m; v.wdata = wd;
        v.ack_dly = dly; v.ack_bits = ab; v.ram_data = rdat; v.io_data = idat;
        v.exp_lat = lat; v.exp_fault = f; v.exp_sel = sel; v.exp_rv = rv;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int c = 0;
        bit seen = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        int exp_rd;
        int exp_wr;
        bit mapped = (v.exp_sel != 2'b00);
        @(negedge clk);
        read_in           = v.rd;
        write_in          = v.wr;
        address_in        = v.addr;
        write_mask_in     = v.mask;
        write_value_in    = v.wdata;
        slv_read_value_in = {v.io_data, v.ram_data};
        slv_ack_in        = 2'b00;
        while (!seen && c < 40) begin
            cycle();
            c++;
            if (slv_read_out)  rd_cnt++;
            if (slv_write_out) wr_cnt++;
            if (c == 1) begin
                check({v.name, " sel"}, 32'(slv_sel_out), 32'(v.exp_sel));
                if (mapped) begin
                    check({v.name, " slv_addr"}, slv_address_out, v.addr);
                    check({v.name, " slv_mask"}, 32'(slv_write_mask_out), 32'(v.mask));
                    check({v.name, " slv_wval"}, slv_write_value_out, v.wdata);
                end
                // upstream changes while the access is in flight must be ignored
                address_in     = ~v.addr;
                write_mask_in  = ~v.mask;
                write_value_in = ~v.wdata;
            end
            if (ready_out) seen = 1;
            else if (v.ack_dly != 0 && c >= int'(v.ack_dly)) slv_ack_in = v.ack_bits;
        end
        exp_rd = (v.rd && mapped) ? int'(v.exp_lat) - 1 : 0;
        exp_wr = (v.wr && mapped) ? int'(v.exp_lat) - 1 : 0;
        check({v.name, " latency"}, 32'(c), 32'(v.exp_lat));
        check({v.name, " fault"}, 32'(fault_out), 32'(v.exp_fault));
        check({v.name, " rvalue"}, read_value_out, v.exp_rv);
        check({v.name, " rd_strobes"}, 32'(rd_cnt), 32'(exp_rd));
        check({v.name, " wr_strobes"}, 32'(wr_cnt), 32'(exp_wr));
        if (mapped) check({v.name, " addr_held"}, slv_address_out, v.addr);
        read_in    = 1'b0;
        write_in   = 1'b0;
        slv_ack_in = 2'b00;
        cycle();
        check({v.name, " ready_drop"}, 32'(ready_out), 32'd0);
        check({v.name, " fault_drop"}, 32'(fault_out), 32'd0);
    endtask

    initial begin
        int rdy_cnt;
        reset = 1'b1; ce_i = 1'b1; address_in = '0; read_in = 1'b0; write_in = 1'b0;
        write_mask_in = '0; write_value_in = '0; slv_read_value_in = '1; slv_ack_in = 2'b11;

        vq.push_back(mk("ram_rd",     1, 0, 32'h0000_0100, 4'h0, 32'h0,          1, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000,  2, 0, 2'b01, 32'hDEAD_BEEF));
        vq.push_back(mk("io_wr",      0, 1, 32'hF000_0004, 4'h3, 32'h1234_5678,  3, 2'b10, 32'h0,         32'h0,          4, 0, 2'b10, 32'hDEAD_BEEF));
        vq.push_back(mk("unmap_rd",   1, 0, 32'h8000_0000, 4'h0, 32'h0,          1, 2'b11, 32'h5555_5555, 32'h6666_6666,  1, 1, 2'b00, 32'hDEAD_BEEF));
        vq.push_back(mk("timeout",    1, 0, 32'h0000_0200, 4'h0, 32'h0,          0, 2'b00, 32'h7777_7777, 32'h0,         17, 1, 2'b01, 32'hDEAD_BEEF));
        vq.push_back(mk("ack_last",   1, 0, 32'h0000_FFFC, 4'h0, 32'h0,         16, 2'b01, 32'hCAFE_F00D, 32'h0,         17, 0, 2'b01, 32'hCAFE_F00D));
        vq.push_back(mk("io_rd",      1, 0, 32'hF000_0FFC, 4'h0, 32'h0,          2, 2'b10, 32'h1111_1111, 32'hA5A5_0F0F,  3, 0, 2'b10, 32'hA5A5_0F0F));
        vq.push_back(mk("rd_and_wr",  1, 1, 32'h0000_0200, 4'hF, 32'h9999_9999,  1, 2'b01, 32'h2222_2222, 32'h0,          1, 1, 2'b00, 32'hA5A5_0F0F));
        vq.push_back(mk("ram_edge",   0, 1, 32'h0001_0000, 4'hF, 32'h3333_3333,  1, 2'b01, 32'h0,         32'h0,          1, 1, 2'b00, 32'hA5A5_0F0F));
        vq.push_back(mk("io_edge",    1, 0, 32'hF000_1000, 4'h0, 32'h0,          1, 2'b10, 32'h0,         32'h4444_4444,  1, 1, 2'b00, 32'hA5A5_0F0F));
        vq.push_back(mk("wrong_ack",  1, 0, 32'h0000_0010, 4'h0, 32'h0,          1, 2'b10, 32'h8888_8888, 32'h9999_9999, 17, 1, 2'b01, 32'hA5A5_0F0F));
        vq.push_back(mk("ram_wr",     0, 1, 32'h0000_0040, 4'hF, 32'h0BAD_C0DE,  1, 2'b11, 32'hABAB_ABAB, 32'hCDCD_CDCD,  2, 0, 2'b01, 32'hA5A5_0F0F));
        vq.push_back(mk("io_rd_both", 1, 0, 32'hF000_0020, 4'h0, 32'h0,          1, 2'b11, 32'h0101_0101, 32'h7654_3210,  2, 0, 2'b10, 32'h7654_3210));

        // reset state, with slave acks and data driven high
        repeat (3) cycle();
        check("rst ready",  32'(ready_out), 32'd0);
        check("rst fault",  32'(fault_out), 32'd0);
        check("rst rvalue", read_value_out, 32'd0);
        check("rst slv",    {slv_address_out[27:0], slv_sel_out, slv_read_out, slv_write_out}, 32'd0);
        check("rst wdata",  {slv_write_value_out[27:0], slv_write_mask_out}, 32'd0);
        slv_ack_in = 2'b00;
        reset = 1'b0;
        cycle();

        foreach (vq[i]) run_vec(vq[i]);

        // clock-enable stall in ACCESS and in RESPOND
        @(negedge clk);
        read_in = 1'b1; address_in = 32'h0000_0100; slv_read_value_in = {32'h0, 32'h1357_9BDF};
        cycle();
        check("ce access", 32'(slv_read_out), 32'd1);
        ce_i = 1'b0; slv_ack_in = 2'b01;
        cycle();
        cycle();
        check("ce hold strobe", 32'(slv_read_out), 32'd1);
        check("ce hold ready",  32'(ready_out), 32'd0);
        ce_i = 1'b1;
        cycle();
        check("ce respond", 32'(ready_out), 32'd1);
        read_in = 1'b0; slv_ack_in = 2'b00; ce_i = 1'b0;
        cycle();
        cycle();
        check("ce hold rdy", 32'(ready_out), 32'd1);
        check("ce rvalue",   read_value_out, 32'h1357_9BDF);
        ce_i = 1'b1;
        cycle();
        check("ce rdy drop", 32'(ready_out), 32'd0);

        // request held across RESPOND: IDLE cycle in between, no back-to-back
        read_in = 1'b1; address_in = 32'h8000_0000;
        cycle();
        check("b2b first", {30'd0, ready_out, fault_out}, 32'd3);
        cycle();
        check("b2b gap", {30'd0, ready_out, fault_out}, 32'd0);
        cycle();
        check("b2b second", {30'd0, ready_out, fault_out}, 32'd3);
        read_in = 1'b0;
        cycle();

        // reset in the second ACCESS cycle, ce low to show reset priority
        read_in = 1'b1; address_in = 32'h0000_0300;
        cycle();
        cycle();
        check("abort strobe", 32'(slv_read_out), 32'd1);
        reset = 1'b1; ce_i = 1'b0; read_in = 1'b0;
        cycle();
        check("abort drop", {29'd0, slv_sel_out, slv_read_out}, 32'd0);
        reset = 1'b0; ce_i = 1'b1;
        slv_ack_in = 2'b01; slv_read_value_in = {32'h0, 32'hBAD0_BAD0};
        rdy_cnt = 0;
        repeat (4) begin
            cycle();
            if (ready_out) rdy_cnt++;
        end
        check("late ack ready", 32'(rdy_cnt), 32'd0);
        check("late ack rvalue", read_value_out, 32'd0);
        slv_ack_in = 2'b00;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
